// File: rtl/wb_dma_copy.sv
`default_nettype none
// ============================================================================
// Module   : wb_dma_copy
// Brief    : Wishbone classic initiator that copies a block of 32-bit words
//            through a one-word buffer, alternating single reads and writes.
//            Optional REQ-phase watchdog: define WB_DMA_COPY_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_dma_copy #(
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             cyc_o,
    output logic             stb_o,
    output logic [31:0]      adr_o,
    output logic             we_o,
    output logic [3:0]       sel_o,
    output logic [31:0]      dat_o,
    input  logic [31:0]      dat_i,
    input  logic             ack_i,
    input  logic             err_i
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_rd_req = 3'd1;
    localparam logic [2:0] c_st_rd_gap = 3'd2;
    localparam logic [2:0] c_st_wr_req = 3'd3;
    localparam logic [2:0] c_st_wr_gap = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;

    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [31:0]      r_buf;
    logic [31:0]      r_adr;
    logic [LEN_W-1:0] r_count;
    logic             r_cyc;
    logic             r_we;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic [31:0]      w_src_nxt;
    logic [31:0]      w_dst_nxt;
    logic [31:0]      w_buf_nxt;
    logic [31:0]      w_adr_nxt;
    logic [LEN_W-1:0] w_count_nxt;
    logic             w_cyc_nxt;
    logic             w_we_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;

    logic             w_req;
    logic             w_tmo_hit;
    logic             w_abort;
    logic             w_unused_addr_bits;

    assign w_req              = (r_state == c_st_rd_req) || (r_state == c_st_wr_req);
    assign w_abort            = w_req && (err_i || w_tmo_hit);
    assign w_unused_addr_bits = ^{src_addr_i[1:0], dst_addr_i[1:0]};

`ifdef WB_DMA_COPY_TIMEOUT_EN
    localparam int c_tmo_w = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [c_tmo_w-1:0] r_tmo;

    // Counter restarts whenever a REQ state is left, so each request starts at zero.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_tmo <= '0;
        end else if (w_req && (w_state_nxt == r_state)) begin
            r_tmo <= r_tmo + 1'b1;
        end else begin
            r_tmo <= '0;
        end
    end

    assign w_tmo_hit = w_req && !ack_i && !err_i &&
                       (r_tmo == c_tmo_w'(TIMEOUT_CYCLES - 1));
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (start_i && (len_i != '0)) begin
                    w_state_nxt = c_st_rd_req;
                end
            end
            c_st_rd_req: begin
                if (w_abort) begin
                    w_state_nxt = c_st_idle;
                end else if (ack_i) begin
                    w_state_nxt = c_st_rd_gap;
                end
            end
            c_st_rd_gap: w_state_nxt = c_st_wr_req;
            c_st_wr_req: begin
                if (w_abort) begin
                    w_state_nxt = c_st_idle;
                end else if (ack_i) begin
                    w_state_nxt = c_st_wr_gap;
                end
            end
            c_st_wr_gap: begin
                w_state_nxt = (r_count == '0) ? c_st_idle : c_st_rd_req;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        w_buf_nxt   = r_buf;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        case (r_state)
            c_st_idle: begin
                if (start_i) begin
                    w_src_nxt   = {src_addr_i[31:2], 2'b00};
                    w_dst_nxt   = {dst_addr_i[31:2], 2'b00};
                    w_count_nxt = len_i;
                    w_err_nxt   = 1'b0;
                    w_done_nxt  = (len_i == '0);
                end
            end
            c_st_rd_req: begin
                if (w_abort) begin
                    w_err_nxt  = 1'b1;
                    w_done_nxt = 1'b1;
                end else if (ack_i) begin
                    w_buf_nxt = dat_i;
                    w_src_nxt = r_src + 32'd4;
                end
            end
            c_st_wr_req: begin
                if (w_abort) begin
                    w_err_nxt  = 1'b1;
                    w_done_nxt = 1'b1;
                end else if (ack_i) begin
                    w_dst_nxt   = r_dst + 32'd4;
                    w_count_nxt = r_count - 1'b1;
                end
            end
            c_st_wr_gap: begin
                w_done_nxt = (r_count == '0);
            end
            default: ;
        endcase

        // Bus outputs are decoded from the next state so they are registered.
        w_cyc_nxt = (w_state_nxt == c_st_rd_req) || (w_state_nxt == c_st_wr_req);
        w_we_nxt  = (w_state_nxt == c_st_wr_req);
        w_adr_nxt = r_adr;
        if (w_state_nxt == c_st_rd_req) begin
            w_adr_nxt = w_src_nxt;
        end else if (w_state_nxt == c_st_wr_req) begin
            w_adr_nxt = w_dst_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_buf   <= '0;
            r_adr   <= '0;
            r_count <= '0;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_src   <= w_src_nxt;
            r_dst   <= w_dst_nxt;
            r_buf   <= w_buf_nxt;
            r_adr   <= w_adr_nxt;
            r_count <= w_count_nxt;
            r_cyc   <= w_cyc_nxt;
            r_we    <= w_we_nxt;
            r_busy  <= (w_state_nxt != c_st_idle);
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign err_o  = r_err;
    assign cyc_o  = r_cyc;
    assign stb_o  = r_cyc;
    assign adr_o  = r_adr;
    assign we_o   = r_we;
    assign sel_o  = 4'hF;
    assign dat_o  = r_buf;

endmodule
`default_nettype wire

// File: tb/tb_wb_dma_copy.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_dma_copy
// Brief    : Directed self-checking bench for wb_dma_copy with a Wishbone slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_dma_copy;

`ifdef WB_DMA_COPY_TIMEOUT_EN
    localparam int c_tmo = 8;
`else
    localparam int c_tmo = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src = '0;
    logic [31:0] dst = '0;
    logic [15:0] len = '0;
    logic        busy, done, err, cyc, stb, we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic [31:0] rdat = '0;
    logic        ack = 1'b0;
    logic        serr = 1'b0;

    wb_dma_copy #(.LEN_W(16), .TIMEOUT_CYCLES(c_tmo)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .src_addr_i(src), .dst_addr_i(dst), .len_i(len),
        .busy_o(busy), .done_o(done), .err_o(err),
        .cyc_o(cyc), .stb_o(stb), .adr_o(adr), .we_o(we), .sel_o(sel),
        .dat_o(wdat), .dat_i(rdat), .ack_i(ack), .err_i(serr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] src_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Slave model: registered ack/err after LAT cycles of strobe.
    int          lat = 1;
    int          err_on_wr = -1;
    bit          noack = 1'b0;
    int          wcnt = 0;
    int          wr_attempts = 0;
    logic [31:0] rd_adr_q[$];
    logic [31:0] wr_adr_q[$];
    logic [31:0] wr_dat_q[$];

    always @(posedge clk) begin
        ack  <= 1'b0;
        serr <= 1'b0;
        if (cyc && stb && !ack && !serr && !noack) begin
            if (wcnt == lat - 1) begin
                wcnt <= 0;
                if (we) begin
                    if (wr_attempts == err_on_wr) serr <= 1'b1;
                    else begin
                        ack <= 1'b1;
                        wr_adr_q.push_back(adr);
                        wr_dat_q.push_back(wdat);
                    end
                    wr_attempts <= wr_attempts + 1;
                end else begin
                    ack  <= 1'b1;
                    rdat <= src_word(adr);
                    rd_adr_q.push_back(adr);
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    // Passive monitors sampled on the falling edge.
    int done_cnt = 0;
    int cyc_seen = 0;
    int sel_bad  = 0;
    int low_run  = 0;
    int gap_q[$];

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (cyc) cyc_seen++;
        if (cyc && we && sel != 4'hF) sel_bad++;
        if (busy && !cyc) low_run++;
        else if (cyc) begin
            if (low_run > 0) gap_q.push_back(low_run);
            low_run = 0;
        end else low_run = 0;
    end

    task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        @(negedge clk);
        src = s; dst = d; len = l; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            @(posedge clk);
            cycles++;
            #1;
            if (done) break;
        end
        if (!done) check("done_wait_expired", 32'd0, 32'd1);
    endtask

    int cyc_n, rb, wb, db, cb, gb, busy_cnt;
    logic [31:0] exp_dat [4] = '{32'h0100_FEFF, 32'h0104_FEFB, 32'h0108_FEF7, 32'h010C_FEF3};
    logic [31:0] wrap_adr [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cyc", {31'd0, cyc}, 32'd0);
        check("rst_stb", {31'd0, stb}, 32'd0);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_adr", adr, 32'd0);
        check("rst_dat", wdat, 32'd0);
        rst_n = 1'b1;

        // 4-word copy, 1-cycle slave
        rb = rd_adr_q.size(); wb = wr_adr_q.size(); db = done_cnt;
        launch(32'h0000_0100, 32'h0000_0200, 16'd4);
        wait_done(200, cyc_n);
        check("copy4_latency", cyc_n, 32'd24);
        check("copy4_err", {31'd0, err}, 32'd0);
        check("copy4_nwr", wr_adr_q.size() - wb, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("copy4_rd_adr", rd_adr_q[rb + i], 32'h100 + 32'(4 * i));
            check("copy4_wr_adr", wr_adr_q[wb + i], 32'h200 + 32'(4 * i));
            check("copy4_wr_dat", wr_dat_q[wb + i], exp_dat[i]);
        end
        @(posedge clk); #1;
        check("copy4_done_once", done_cnt - db, 32'd1);
        check("copy4_sel", sel_bad, 32'd0);
        check("copy4_busy_after", {31'd0, busy}, 32'd0);

        // Zero length
        cb = cyc_seen; db = done_cnt;
        launch(32'h0000_0100, 32'h0000_0200, 16'd0);
        check("len0_done_next", {31'd0, done}, 32'd1);
        check("len0_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("len0_done_low", {31'd0, done}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("len0_no_cyc", cyc_seen - cb, 32'd0);
        check("len0_done_cnt", done_cnt - db, 32'd1);

        // Error on second write of a 3-word copy
        wb = wr_adr_q.size();
        err_on_wr = wr_attempts + 1;
        launch(32'h0000_0300, 32'h0000_0400, 16'd3);
        wait_done(200, cyc_n);
        check("err_latency", cyc_n, 32'd11);
        check("err_flag", {31'd0, err}, 32'd1);
        check("err_cyc_drop", {31'd0, cyc}, 32'd0);
        check("err_nwr", wr_adr_q.size() - wb, 32'd1);
        check("err_wr0_adr", wr_adr_q[wb], 32'h0000_0400);
        check("err_wr0_dat", wr_dat_q[wb], 32'h0300_FCFF);
        err_on_wr = -1;
        repeat (3) @(posedge clk);
        check("err_sticky", {31'd0, err}, 32'd1);
        launch(32'h0000_0500, 32'h0000_0600, 16'd1);
        check("err_cleared_on_start", {31'd0, err}, 32'd0);
        wait_done(200, cyc_n);
        check("after_err_latency", cyc_n, 32'd6);
        check("after_err_flag", {31'd0, err}, 32'd0);

        // Address wrap and alignment
        rb = rd_adr_q.size(); wb = wr_adr_q.size();
        launch(32'hFFFF_FFF8, 32'h0000_0700, 16'd3);
        wait_done(200, cyc_n);
        check("wrap_latency", cyc_n, 32'd18);
        for (int i = 0; i < 3; i++) check("wrap_rd_adr", rd_adr_q[rb + i], wrap_adr[i]);
        check("wrap_wr2_dat", wr_dat_q[wb + 2], 32'h0000_FFFF);
        rb = rd_adr_q.size(); wb = wr_adr_q.size();
        launch(32'h0000_0103, 32'h0000_0803, 16'd1);
        wait_done(200, cyc_n);
        check("unal_rd_adr", rd_adr_q[rb], 32'h0000_0100);
        check("unal_wr_adr", wr_adr_q[wb], 32'h0000_0800);

        // Slow slave, start pulse while busy
        lat = 3;
        rb = rd_adr_q.size(); wb = wr_adr_q.size(); gb = gap_q.size();
        launch(32'h0000_0900, 32'h0000_0A00, 16'd2);
        repeat (5) @(posedge clk);
        launch(32'h0000_0B00, 32'h0000_0C00, 16'd5);
        wait_done(200, cyc_n);
        check("slow_latency", cyc_n + 6, 32'd20);
        check("slow_nrd", rd_adr_q.size() - rb, 32'd2);
        check("slow_rd1_adr", rd_adr_q[rb + 1], 32'h0000_0904);
        check("slow_wr1_adr", wr_adr_q[wb + 1], 32'h0000_0A04);
        check("slow_wr1_dat", wr_dat_q[wb + 1], 32'h0904_F6FB);
        check("slow_ngaps", gap_q.size() - gb, 32'd3);
        for (int i = gb; i < gap_q.size(); i++) check("slow_gap_len", gap_q[i], 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("slow_ignored_start", {31'd0, busy}, 32'd0);
        lat = 1;

        // Slave that never acknowledges
        noack = 1'b1;
        launch(32'h0000_0D00, 32'h0000_0E00, 16'd1);
`ifdef WB_DMA_COPY_TIMEOUT_EN
        wait_done(100, cyc_n);
        check("tmo_latency", cyc_n, 32'd8);
        check("tmo_err", {31'd0, err}, 32'd1);
        check("tmo_cyc", {31'd0, cyc}, 32'd0);
        launch(32'h0000_0D00, 32'h0000_0E00, 16'd1);
        repeat (3) @(posedge clk);
`else
        busy_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (busy) busy_cnt++;
        end
        check("noack_busy_held", busy_cnt, 32'd1000);
        check("noack_cyc_held", {31'd0, cyc}, 32'd1);
`endif
        // Reset mid-transfer
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_cyc", {31'd0, cyc}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        cb = cyc_seen;
        @(negedge clk);
        rst_n = 1'b1;
        noack = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_no_bus", cyc_seen - cb, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
